write_part_ctrl: RTL

- Write-side pointer and flag controller for the asynchronous FIFO, in the w_clk domain. It is the counterpart of the read-side controller.
- It produces the binary write address for the dual-port RAM and the Gray write pointer exported to the read domain.
- It synchronises the read Gray pointer into w_clk and generates full, almost-full, fill level and overflow status.

---
 rtl/write_part_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/write_part_ctrl.sv
// Write-side pointer and flag controller for the asynchronous FIFO (w_clk domain).
// Owns the binary/Gray write pointer, synchronises the read Gray pointer and
// derives full, almost-full, fill level and overflow status from them.
module write_part_ctrl #(
   parameter int unsigned WIDTH_A  = 8,
   parameter int unsigned AF_LEVEL = (2 ** WIDTH_A) - 4
) (
   input  logic               w_clk,
   input  logic               w_rst,
   input  logic               w_req,
   input  logic [WIDTH_A:0]   r_gaddr,
   input  logic               w_ovf_clr,
   output logic               w_en,
   output logic [WIDTH_A:0]   w_addr,
   output logic [WIDTH_A:0]   w_gaddr,
   output logic               w_full,
   output logic               w_almost_full,
   output logic [WIDTH_A:0]   w_level,
   output logic               w_overflow,
   output logic [7:0]         w_drop_cnt
);

   localparam int unsigned PW       = WIDTH_A + 1;
   localparam int unsigned DROP_W   = 8;
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   logic [PW-1:0]     rg1;
   logic [PW-1:0]     rg2;
   logic [PW-1:0]     rb;
   logic [PW-1:0]     full_pat;
   logic [PW-1:0]     w_addr_nxt;
   logic [PW-1:0]     w_gaddr_nxt;
   logic [PW-1:0]     level_nxt;
   logic              accept;
   logic              reject;
   logic              ovf_nxt;
   logic [DROP_W-1:0] drop_nxt;

   // Write accepted this cycle only when not full; RAM enable follows directly.
   assign accept = w_req & ~w_full;
   assign reject = w_req & w_full;
   assign w_en   = accept;

   // Next pointer, its Gray code and the fill level it implies against the synced read pointer.
   assign w_addr_nxt  = w_addr + PW'(accept);
   assign w_gaddr_nxt = w_addr_nxt ^ (w_addr_nxt >> 1);
   assign level_nxt   = w_addr_nxt - rb;

   // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted.
   if (WIDTH_A == 1) begin : g_full_w1
      assign full_pat = ~rg2;
   end else begin : g_full_wn
      assign full_pat = {~rg2[PW-1:PW-2], rg2[PW-3:0]};
   end

   // Gray-to-binary of the synchronised read pointer: each bit is the XOR of itself and all bits above.
   always_comb begin
      rb = '0;
      for (int i = 0; i < int'(PW); i++) begin
         rb[i] = ^(rg2 >> i);
      end
   end

   // Overflow bookkeeping: a clear on the same edge is applied before the new rejection is counted.
   always_comb begin
      ovf_nxt  = w_overflow;
      drop_nxt = w_drop_cnt;
      if (w_ovf_clr) begin
         ovf_nxt  = 1'b0;
         drop_nxt = '0;
      end
      if (reject) begin
         ovf_nxt = 1'b1;
         if (drop_nxt != DROP_MAX) begin
            drop_nxt = drop_nxt + DROP_W'(1);
         end
      end
   end

   // Two-flop synchroniser for the read Gray pointer.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         rg1 <= '0;
         rg2 <= '0;
      end else begin
         rg1 <= r_gaddr;
         rg2 <= rg1;
      end
   end

   // Pointer and status registers, all updated from the next pointer and the pre-edge synced read pointer.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         w_addr        <= '0;
         w_gaddr       <= '0;
         w_full        <= 1'b0;
         w_almost_full <= 1'b0;
         w_level       <= '0;
         w_overflow    <= 1'b0;
         w_drop_cnt    <= '0;
      end else begin
         w_addr        <= w_addr_nxt;
         w_gaddr       <= w_gaddr_nxt;
         w_full        <= (w_gaddr_nxt == full_pat);
         w_almost_full <= (level_nxt >= PW'(AF_LEVEL));
         w_level       <= level_nxt;
         w_overflow    <= ovf_nxt;
         w_drop_cnt    <= drop_nxt;
      end
   end

endmodule
